// File: rtl/segre_dcache_mmu_if.sv
// segre_dcache_mmu_if
//   Bundles the signals that connect the TL-stage dcache miss responder to
//   its two neighbours:
//   - the TL stage, which issues dcache accesses and consumes fills;
//   - the memory, which serves lane-aligned line reads.
//   Signal names keep the _i/_o suffixes as seen from the responder.
//
//   Modports:
//   - slave  : the responder (segre_dcache_mmu).
//   - master : whoever drives the TL-stage and memory sides (pipeline or bench).
//
//   Signals:
//   - cache_access_i : TL stage dcache access this cycle.
//   - miss_i         : access missed (qualified by cache_access_i).
//   - addr_i         : miss -> full byte address; hit -> line index in low bits.
//   - data_rdy_o     : one-cycle pulse, fill line valid.
//   - data_o         : fill line.
//   - lru_index_o    : victim line to refill.
//   - busy_o         : miss in progress.
//   - mem_rd_o       : memory read request (level).
//   - mem_addr_o     : lane-aligned read address.
//   - mem_rdy_i      : memory response valid.
//   - mem_data_i     : memory response line.
interface segre_dcache_mmu_if #(
  parameter int ADDR_SIZE         = 32,
  parameter int DCACHE_LANE_SIZE  = 128,
  parameter int DCACHE_INDEX_SIZE = 2
);
  logic                         cache_access_i;
  logic                         miss_i;
  logic [ADDR_SIZE-1:0]         addr_i;
  logic                         data_rdy_o;
  logic [DCACHE_LANE_SIZE-1:0]  data_o;
  logic [DCACHE_INDEX_SIZE-1:0] lru_index_o;
  logic                         busy_o;
  logic                         mem_rd_o;
  logic [ADDR_SIZE-1:0]         mem_addr_o;
  logic                         mem_rdy_i;
  logic [DCACHE_LANE_SIZE-1:0]  mem_data_i;

  modport slave (
    input  cache_access_i, miss_i, addr_i, mem_rdy_i, mem_data_i,
    output data_rdy_o, data_o, lru_index_o, busy_o, mem_rd_o, mem_addr_o
  );

  modport master (
    output cache_access_i, miss_i, addr_i, mem_rdy_i, mem_data_i,
    input  data_rdy_o, data_o, lru_index_o, busy_o, mem_rd_o, mem_addr_o
  );
endinterface

// File: rtl/segre_dcache_mmu.sv
// segre_dcache_mmu
//   Responder side of the TL-stage dcache miss interface.
//
//   LRU tracking:
//   - Keeps a true-LRU age counter per line of a fully associative dcache.
//   - Ages always form a permutation of 0..N-1 (0 = MRU).
//   - Hits touch the addressed line in any state.
//
//   Miss handling:
//   - A miss accepted in IDLE latches the LRU line as victim and issues a
//     lane-aligned memory read.
//   - The returned line is presented for one cycle together with the victim
//     index.
//   - The victim is then made MRU.
//
//   Ports:
//   - clk_i : clock, rising edge.
//   - rst_i : synchronous reset, active-high.
//   - bus   : segre_dcache_mmu_if.slave carrying TL-stage and memory signals.
module segre_dcache_mmu #(
  parameter int ADDR_SIZE         = 32,
  parameter int DCACHE_LANE_SIZE  = 128,
  parameter int DCACHE_BYTE_SIZE  = 4,
  parameter int DCACHE_NUM_LINES  = 4,
  parameter int DCACHE_INDEX_SIZE = 2
) (
  input logic               clk_i,
  input logic               rst_i,
  segre_dcache_mmu_if.slave bus
);

  // A single-line cache still needs a 1-bit age/index internally.
  localparam int IW = (DCACHE_INDEX_SIZE > 0) ? DCACHE_INDEX_SIZE : 1;
  localparam int N  = DCACHE_NUM_LINES;
  localparam logic [IW-1:0] AGE_MAX = IW'(N - 1);

  typedef logic [N-1:0][IW-1:0] age_vec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  age_vec_t                    age_q, age_d;
  logic [IW-1:0]               victim_q, victim_d;
  logic [IW-1:0]               lru_index_q, lru_index_d;
  logic                        data_rdy_q, data_rdy_d;
  logic [DCACHE_LANE_SIZE-1:0] data_q, data_d;
  logic                        mem_rd_q, mem_rd_d;
  logic [ADDR_SIZE-1:0]        mem_addr_q, mem_addr_d;

  logic [N-1:0]  is_lru;
  logic [IW-1:0] lru_line;
  logic [IW-1:0] hit_index;

  assign hit_index = bus.addr_i[IW-1:0];

  // Move line k to MRU; only lines younger than k age, so the ages stay a
  // permutation and touching the current MRU is a no-op.
  function automatic age_vec_t touch(input age_vec_t a, input logic [IW-1:0] k);
    age_vec_t r;
    r = a;
    for (int j = 0; j < N; j++) begin
      if (a[j] < a[k]) begin
        r[j] = a[j] + 1'b1;
      end
    end
    r[k] = '0;
    return r;
  endfunction

  // Exactly one line carries the maximum age; find it.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lru
      assign is_lru[gi] = (age_q[gi] == AGE_MAX);
    end
  endgenerate

  always_comb begin
    lru_line = '0;
    for (int i = 0; i < N; i++) begin
      if (is_lru[i]) begin
        lru_line = IW'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    age_d       = age_q;
    victim_d    = victim_q;
    lru_index_d = lru_index_q;
    data_rdy_d  = 1'b0;
    data_d      = data_q;
    mem_rd_d    = mem_rd_q;
    mem_addr_d  = mem_addr_q;

    // Hit touch comes first so that a fill touch in the same cycle wins MRU.
    if (bus.cache_access_i && !bus.miss_i) begin
      age_d = touch(age_d, hit_index);
    end

    unique case (state_q)
      IDLE: begin
        if (bus.cache_access_i && bus.miss_i) begin
          victim_d   = lru_line;
          mem_addr_d = {bus.addr_i[ADDR_SIZE-1:DCACHE_BYTE_SIZE], {DCACHE_BYTE_SIZE{1'b0}}};
          mem_rd_d   = 1'b1;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_rdy_i) begin
          data_d      = bus.mem_data_i;
          lru_index_d = victim_q;
          mem_rd_d    = 1'b0;
          data_rdy_d  = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        age_d   = touch(age_d, victim_q);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      victim_q    <= '0;
      lru_index_q <= '0;
      data_rdy_q  <= 1'b0;
      data_q      <= '0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      // Line 0 starts as LRU so the first fills go to 0, 1, 2, ...
      for (int i = 0; i < N; i++) begin
        age_q[i] <= IW'(N - 1 - i);
      end
    end else begin
      state_q     <= state_d;
      age_q       <= age_d;
      victim_q    <= victim_d;
      lru_index_q <= lru_index_d;
      data_rdy_q  <= data_rdy_d;
      data_q      <= data_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  assign bus.data_rdy_o  = data_rdy_q;
  assign bus.data_o      = data_q;
  assign bus.lru_index_o = lru_index_q[DCACHE_INDEX_SIZE-1:0];
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.mem_rd_o    = mem_rd_q;
  assign bus.mem_addr_o  = mem_addr_q;

endmodule

// File: tb/tb_segre_dcache_mmu.sv
// Bench for segre_dcache_mmu.
//   - Stimulus (directed scenarios plus random cycles) updates a behavioural
//     LRU/miss model at every rising edge.
//   - The model pushes expected read addresses and fills into queues.
//   - A monitor on the falling edge compares the DUT against them.
module tb_segre_dcache_mmu;

  localparam int N = 4;

  logic clk;
  logic rst_i;

  segre_dcache_mmu_if #(.ADDR_SIZE(32), .DCACHE_LANE_SIZE(128), .DCACHE_INDEX_SIZE(2)) bus ();

  segre_dcache_mmu #(
    .ADDR_SIZE(32), .DCACHE_LANE_SIZE(128), .DCACHE_BYTE_SIZE(4),
    .DCACHE_NUM_LINES(N), .DCACHE_INDEX_SIZE(2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    int           idx;
  } fill_t;

  // Reference model: ages per line, miss phase (0 idle, 1 waiting, 2 responding).
  int           m_age[N];
  int           m_phase;
  int           m_victim;
  logic [31:0]  addr_q[$];
  fill_t        fill_q[$];

  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;
  bit  prev_rd = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_find_lru();
    for (int i = 0; i < N; i++) begin
      if (m_age[i] == N - 1) return i;
    end
    return 0;
  endfunction

  task automatic m_touch(input int k);
    int old;
    old = m_age[k];
    for (int j = 0; j < N; j++) begin
      if (m_age[j] < old) m_age[j]++;
    end
    m_age[k] = 0;
  endtask

  task automatic m_reset();
    for (int i = 0; i < N; i++) m_age[i] = N - 1 - i;
    m_phase  = 0;
    m_victim = 0;
    addr_q.delete();
    fill_q.delete();
  endtask

  task automatic model_edge(input bit r, input bit acc, input bit ms, input logic [31:0] a,
                            input bit rdy, input logic [127:0] d);
    fill_t f;
    if (r) begin
      m_reset();
      return;
    end
    if (acc && !ms) m_touch(int'(a[1:0]));
    case (m_phase)
      0: if (acc && ms) begin
        m_victim = m_find_lru();
        addr_q.push_back({a[31:4], 4'h0});
        m_phase = 1;
      end
      1: if (rdy) begin
        f.data = d;
        f.idx  = m_victim;
        fill_q.push_back(f);
        m_phase = 2;
      end
      default: begin
        m_touch(m_victim);
        m_phase = 0;
      end
    endcase
  endtask

  // Called at a falling edge; applies inputs for one cycle, updates the model
  // at the rising edge and returns at the next falling edge.
  task automatic drive(input bit r, input bit acc, input bit ms, input logic [31:0] a,
                       input bit rdy, input logic [127:0] d);
    rst_i              = r;
    bus.cache_access_i = acc;
    bus.miss_i         = ms;
    bus.addr_i         = a;
    bus.mem_rdy_i      = rdy;
    bus.mem_data_i     = d;
    @(posedge clk);
    model_edge(r, acc, ms, a, rdy, d);
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 128'h0);
  endtask

  // Full miss: request, 'delay' wait cycles (optional hit each), memory
  // response, then the response cycle (optional hit).
  task automatic do_miss(input logic [31:0] a, input logic [127:0] d, input int delay,
                         input int wait_hit, input int resp_hit);
    drive(1'b0, 1'b1, 1'b1, a, 1'b0, 128'h0);
    for (int i = 0; i < delay; i++)
      drive(1'b0, wait_hit >= 0, 1'b0, 32'(wait_hit & 3), 1'b0, 128'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, d);
    drive(1'b0, resp_hit >= 0, 1'b0, 32'(resp_hit & 3), 1'b0, 128'h0);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor / scoreboard.
  initial begin
    fill_t f;
    logic [31:0] ea;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("busy_o", 128'(bus.busy_o), 128'(m_phase != 0));
        check("mem_rd_o", 128'(bus.mem_rd_o), 128'(m_phase == 1));
        check("data_rdy_o", 128'(bus.data_rdy_o), 128'(m_phase == 2));
        if (bus.mem_rd_o && !prev_rd) begin
          if (addr_q.size() == 0) begin
            check("unexpected_mem_rd", 128'(1), 128'(0));
          end else begin
            ea = addr_q.pop_front();
            check("mem_addr_o", 128'(bus.mem_addr_o), 128'(ea));
            $display("read  addr=%08h", bus.mem_addr_o);
          end
        end
        if (bus.data_rdy_o) begin
          if (fill_q.size() == 0) begin
            check("unexpected_data_rdy", 128'(1), 128'(0));
          end else begin
            f = fill_q.pop_front();
            check("data_o", bus.data_o, f.data);
            check("lru_index_o", 128'(bus.lru_index_o), 128'(f.idx));
            $display("fill  line=%0d data=%032h", bus.lru_index_o, bus.data_o);
          end
        end
        prev_rd = bus.mem_rd_o;
      end
    end
  end

  initial begin
    int v;
    logic [31:0] a;
    bit r, acc, ms, rdy;

    rst_i = 1'b1;
    bus.cache_access_i = 1'b0;
    bus.miss_i = 1'b0;
    bus.addr_i = '0;
    bus.mem_rdy_i = 1'b0;
    bus.mem_data_i = '0;
    m_reset();
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 128'h0);
    mon_en = 1'b1;
    check("reset_data_o", bus.data_o, 128'h0);
    check("reset_lru_index_o", 128'(bus.lru_index_o), 128'h0);
    check("reset_mem_addr_o", 128'(bus.mem_addr_o), 128'h0);

    // Single miss with a 3-cycle mem_rd_o burst.
    do_miss(32'h0000_1234, {16{8'hA5}}, 2, -1, -1);
    idle_cycle();

    // Four fills from reset walk the lines in order, then wrap.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 128'h0);
    do_miss(32'h100, rand128(), 0, -1, -1);
    do_miss(32'h200, rand128(), 0, -1, -1);
    do_miss(32'h300, rand128(), 0, -1, -1);
    do_miss(32'h400, rand128(), 0, -1, -1);
    do_miss(32'h500, rand128(), 0, -1, -1);

    // Hits on 0 then 1, then misses expose the resulting LRU order.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 128'h0);
    for (int i = 0; i < 4; i++) do_miss(32'h100 * (i + 1), rand128(), 0, -1, -1);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 128'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h1, 1'b0, 128'h0);
    for (int i = 0; i < 4; i++) do_miss(32'h1000 + 32'h40 * i, rand128(), 1, -1, -1);

    // Stray mem_rdy_i in IDLE, second miss during WAIT and during RESP.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, rand128());
    drive(1'b0, 1'b1, 1'b1, 32'h900, 1'b0, 128'h0);
    drive(1'b0, 1'b1, 1'b1, 32'h800, 1'b0, 128'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, rand128());
    drive(1'b0, 1'b1, 1'b1, 32'h800, 1'b0, 128'h0);
    idle_cycle();

    // Hit on the latched victim during WAIT, hit on another line in RESP.
    v = m_find_lru();
    do_miss(32'hA00, rand128(), 2, v, (v + 1) % N);
    for (int i = 0; i < 4; i++) do_miss(32'hB00 + 32'h10 * i, rand128(), 0, -1, -1);

    // Reset during WAIT aborts the miss; the late response is ignored.
    drive(1'b0, 1'b1, 1'b1, 32'hC00, 1'b0, 128'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 128'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 128'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, rand128());
    do_miss(32'hD00, rand128(), 1, -1, -1);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      r   = ($urandom % 80) == 0;
      acc = $urandom % 2;
      ms  = ($urandom % 3) == 0;
      a   = ms ? $urandom : 32'($urandom % N);
      rdy = ($urandom % 3) == 0;
      drive(r, acc, ms, a, rdy, rand128());
    end
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, rand128());
    idle_cycle();
    idle_cycle();

    check("pending_fills", 128'(fill_q.size()), 128'(0));
    check("pending_reads", 128'(addr_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/segre_dcache_mmu.md
Name: segre_dcache_mmu

Overview:
- Responder side of the TL-stage dcache miss interface.
- Accepts dcache accesses from the TL stage and tracks LRU state over all dcache lines (fully associative). Hits update LRU.
- On a miss, fetches the lane-aligned line from memory and returns the line, data_rdy and the victim index, so the tag array can refill that line.

Parameters:
ADDR_SIZE, 32, address width
DCACHE_LANE_SIZE, 128, line width in bits
DCACHE_BYTE_SIZE, 4, log2 of line bytes (offset bits)
DCACHE_NUM_LINES, 4, number of dcache lines
DCACHE_INDEX_SIZE, 2, log2(DCACHE_NUM_LINES)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
cache_access_i  in  1  TL stage dcache access this cycle
miss_i  in  1  access missed dcache and store buffer; qualified by cache_access_i
addr_i  in  ADDR_SIZE  miss: full byte address; hit: line index in [DCACHE_INDEX_SIZE-1:0], upper bits zero
data_rdy_o  out  1  one-cycle pulse: fill line valid
data_o  out  DCACHE_LANE_SIZE  fill line
lru_index_o  out  DCACHE_INDEX_SIZE  victim line to refill
busy_o  out  1  miss in progress (state != IDLE)
mem_rd_o  out  1  memory read request, level
mem_addr_o  out  ADDR_SIZE  lane-aligned read address
mem_rdy_i  in  1  memory response valid
mem_data_i  in  DCACHE_LANE_SIZE  memory response line

Behaviour:
- Reset (rst_i high at an edge):
  - All outputs go to 0 and the FSM goes to IDLE.
  - age[i] = DCACHE_NUM_LINES-1-i, so line 0 is the first victim.
  - Reset mid-miss aborts the miss: no data_rdy_o, and a later mem_rdy_i is ignored.
- LRU state:
  - One age counter per line, DCACHE_INDEX_SIZE bits wide.
  - The ages always form a permutation of 0..N-1: 0 = MRU, N-1 = LRU.
- touch(k):
  - Every line j with age[j] < age[k] increments.
  - age[k] is set to 0.
  - Touching the current MRU line changes nothing.
- Hit update: when cache_access_i=1 and miss_i=0, touch(addr_i[DCACHE_INDEX_SIZE-1:0]) at the next edge. This applies in every FSM state.
- FSM states: IDLE, WAIT, RESP.
  - IDLE, cache_access_i & miss_i:
    - Latch victim = index whose age is N-1.
    - Latch mem_addr_o = {addr_i[ADDR_SIZE-1:DCACHE_BYTE_SIZE], zeros}.
    - Set mem_rd_o=1 and go to WAIT.
  - WAIT:
    - mem_rd_o stays high.
    - When mem_rdy_i=1: capture mem_data_i into data_o, set lru_index_o=victim, clear mem_rd_o, go to RESP.
  - RESP:
    - data_rdy_o=1 for exactly this cycle.
    - At the edge leaving RESP: touch(victim), go to IDLE, data_rdy_o returns to 0.
- Latency: miss sampled at edge 0 gives mem_rd_o high after edge 0. mem_rdy_i sampled at edge N gives data_rdy_o high for the cycle after edge N.
  - Minimum: mem_rdy_i at edge 1 gives data_rdy_o after edge 1, back to IDLE after edge 2.
- data_o and lru_index_o hold their values until the next fill. They are meaningful only while data_rdy_o=1.
- Boundary conditions:
  - A miss (cache_access_i & miss_i) outside IDLE is ignored. The TL stage holds its hazard and re-presents the request after returning to IDLE.
  - A miss presented in the same cycle as data_rdy_o=1 is not accepted.
  - mem_rdy_i outside WAIT is ignored.
  - The victim is fixed at latch time. A hit to the victim index during WAIT still touches it, but the fill still targets the latched victim.
  - Hit touch and fill touch at the same edge (RESP): apply the hit touch first, then touch(victim). The victim ends as MRU.
  - With DCACHE_NUM_LINES=1, victim is always 0 and ages stay 0.

Test Plan:
- Reset, then miss at addr_i=0x0000_1234; mem_rdy_i 3 cycles later with mem_data_i=0xA5A5…A5 -> mem_addr_o=0x0000_1230, mem_rd_o high for 3 cycles, then data_rdy_o one-cycle pulse with data_o=0xA5A5…A5 and lru_index_o=0; busy_o low afterwards.
- From reset, four back-to-back misses (0x100, 0x200, 0x300, 0x400), each with mem_rdy_i one cycle after mem_rd_o -> lru_index_o = 0, 1, 2, 3 in order; a fifth miss gives lru_index_o=0.
- After the four fills, hits on index 0 then index 1, then a miss -> lru_index_o=2; ages afterwards are line2=0, line1=1, line0=2, line3=3.
- During WAIT: a second miss at 0x800 plus a stray mem_rdy_i while in IDLE before it -> only one mem_rd_o burst; the second miss is not latched; exactly one data_rdy_o pulse.
- Hit on the victim index during WAIT, then fill -> lru_index_o equals the latched victim; in RESP, a simultaneous hit on another index leaves the victim with age 0 and the hit line with age 1.
- rst_i asserted in WAIT, then mem_rdy_i=1 next cycle -> no data_rdy_o; mem_rd_o=0; ages restored to reset values; next miss gets lru_index_o=0.
